// File: rtl/pc_sequencer.sv
// Program counter sequencer: NEXT/JUMP/CALL/RET/RETI commands, single-level
// interrupt entry, and a sticky fault state driving an external PC stack.
module pc_sequencer #(
  parameter logic [10:0] RESET_VECTOR = 11'h000,
  parameter logic [10:0] IRQ_VECTOR   = 11'h7F0,
  parameter int          DEPTH        = 32
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [10:0] target,
  output logic        cmd_ready,
  input  logic        irq_req,
  input  logic        irq_en,
  output logic        irq_ack,
  output logic [10:0] pc,
  output logic        stack_push,
  output logic [10:0] stack_push_data,
  output logic        stack_pop,
  input  logic [10:0] stack_pop_data,
  output logic [5:0]  depth,
  output logic        in_isr,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_RETI = 3'd4;

  localparam logic [1:0] FC_OVF = 2'd1;
  localparam logic [1:0] FC_UNF = 2'd2;
  localparam logic [1:0] FC_ILL = 2'd3;

  localparam logic [5:0] DEPTH_MAX = 6'(DEPTH);

  state_t      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [5:0]  depth_q, depth_d;
  logic        irq_pending_q, irq_pending_d;
  logic        in_isr_q, in_isr_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;

  logic        take_irq;
  logic        stack_full, stack_empty;
  logic        fault_now;
  logic [1:0]  fault_now_code;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    depth_d         = depth_q;
    irq_pending_d   = irq_pending_q;
    in_isr_d        = in_isr_q;
    fault_d         = fault_q;
    fault_code_d    = fault_code_q;
    cmd_ready       = 1'b0;
    irq_ack         = 1'b0;
    stack_push      = 1'b0;
    stack_pop       = 1'b0;
    stack_push_data = pc_q + 11'd1;
    take_irq        = 1'b0;
    fault_now       = 1'b0;
    fault_now_code  = 2'd0;
    stack_full      = (depth_q == DEPTH_MAX);
    stack_empty     = (depth_q == 6'd0);

    if (state_q == RUN) begin
      // Interrupt entry pre-empts whatever command is offered this cycle.
      take_irq  = irq_pending_q && irq_en && !in_isr_q;
      cmd_ready = !take_irq;
      if (take_irq) begin
        if (stack_full) begin
          fault_now      = 1'b1;
          fault_now_code = FC_OVF;
        end else begin
          stack_push      = 1'b1;
          stack_push_data = pc_q;
          pc_d            = IRQ_VECTOR;
          depth_d         = depth_q + 6'd1;
          in_isr_d        = 1'b1;
          irq_ack         = 1'b1;
          irq_pending_d   = 1'b0;
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          OP_NEXT: pc_d = pc_q + 11'd1;
          OP_JUMP: pc_d = target;
          OP_CALL: begin
            if (stack_full) begin
              fault_now      = 1'b1;
              fault_now_code = FC_OVF;
            end else begin
              stack_push = 1'b1;
              pc_d       = target;
              depth_d    = depth_q + 6'd1;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              fault_now      = 1'b1;
              fault_now_code = FC_UNF;
            end else begin
              stack_pop = 1'b1;
              pc_d      = stack_pop_data;
              depth_d   = depth_q - 6'd1;
            end
          end
          OP_RETI: begin
            // Returning from a handler that is not running is the worse error.
            if (!in_isr_q) begin
              fault_now      = 1'b1;
              fault_now_code = FC_ILL;
            end else if (stack_empty) begin
              fault_now      = 1'b1;
              fault_now_code = FC_UNF;
            end else begin
              stack_pop = 1'b1;
              pc_d      = stack_pop_data;
              depth_d   = depth_q - 6'd1;
              in_isr_d  = 1'b0;
            end
          end
          default: begin
            fault_now      = 1'b1;
            fault_now_code = FC_ILL;
          end
        endcase
      end

      if (fault_now) begin
        state_d      = FAULT;
        fault_d      = 1'b1;
        fault_code_d = fault_now_code;
      end
    end

    if (irq_req) irq_pending_d = 1'b1;

    if (rst) begin
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      irq_ack    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_VECTOR;
      depth_q       <= 6'd0;
      irq_pending_q <= 1'b0;
      in_isr_q      <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= 2'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      depth_q       <= depth_d;
      irq_pending_q <= irq_pending_d;
      in_isr_q      <= in_isr_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
    end
  end

  assign pc         = pc_q;
  assign depth      = depth_q;
  assign in_isr     = in_isr_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random commands, all
// checked against a queue-based reference model of the sequencer.
module tb_pc_sequencer;

  localparam int RV    = 'h000;
  localparam int IV    = 'h7F0;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [10:0] target = 11'd0;
  logic        cmd_ready;
  logic        irq_req = 1'b0;
  logic        irq_en = 1'b0;
  logic        irq_ack;
  logic [10:0] pc;
  logic        stack_push;
  logic [10:0] stack_push_data;
  logic        stack_pop;
  logic [10:0] stack_pop_data = 11'd0;
  logic [5:0]  depth;
  logic        in_isr;
  logic        fault;
  logic [1:0]  fault_code;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .target(target),
    .cmd_ready(cmd_ready), .irq_req(irq_req), .irq_en(irq_en), .irq_ack(irq_ack),
    .pc(pc), .stack_push(stack_push), .stack_push_data(stack_push_data),
    .stack_pop(stack_pop), .stack_pop_data(stack_pop_data), .depth(depth),
    .in_isr(in_isr), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pc;
  int stk[$];
  bit m_pend, m_isr, m_fault;
  int m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("depth", 32'(depth), 32'(stk.size()));
    chk("in_isr", 32'(in_isr), 32'(m_isr));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_code", 32'(fault_code), 32'(m_code));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; target = 11'h123; irq_req = 1'b0;
    #1;
    chk("rst_push", 32'(stack_push), 32'd0);
    chk("rst_pop", 32'(stack_pop), 32'd0);
    chk("rst_ack", 32'(irq_ack), 32'd0);
    @(posedge clk); #1;
    m_pc = RV; stk.delete(); m_pend = 0; m_isr = 0; m_fault = 0; m_code = 0;
    check_state();
  endtask

  task automatic set_fault(input int c);
    m_fault = 1; m_code = c;
  endtask

  task automatic step(input bit v, input int op, input int tgt, input bit irq, input bit en);
    bit take, e_ready, e_push, e_pop, e_ack, n_pend;
    int e_pdata;
    @(negedge clk);
    rst = 1'b0; cmd_valid = v; cmd_op = 3'(op); target = 11'(tgt);
    irq_req = irq; irq_en = en;
    stack_pop_data = (stk.size() > 0) ? 11'(stk[$]) : 11'($urandom_range(0, 2047));
    take = !m_fault && m_pend && en && !m_isr;
    e_ready = !m_fault && !take;
    e_push = 0; e_pop = 0; e_ack = 0; e_pdata = 0;
    n_pend = m_pend;
    if (take) begin
      if (stk.size() < DEPTH) begin
        e_push = 1; e_pdata = m_pc; e_ack = 1;
        stk.push_back(m_pc); m_pc = IV; m_isr = 1; n_pend = 0;
      end else set_fault(1);
    end else if (!m_fault && v) begin
      case (op)
        0: m_pc = (m_pc + 1) % 2048;
        1: m_pc = tgt;
        2: if (stk.size() < DEPTH) begin
             e_push = 1; e_pdata = (m_pc + 1) % 2048;
             stk.push_back(e_pdata); m_pc = tgt;
           end else set_fault(1);
        3: if (stk.size() > 0) begin e_pop = 1; m_pc = stk.pop_back(); end
           else set_fault(2);
        4: if (!m_isr) set_fault(3);
           else if (stk.size() == 0) set_fault(2);
           else begin e_pop = 1; m_pc = stk.pop_back(); m_isr = 0; end
        default: set_fault(3);
      endcase
    end
    if (irq) n_pend = 1;
    m_pend = n_pend;
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    chk("stack_push", 32'(stack_push), 32'(e_push));
    chk("stack_pop", 32'(stack_pop), 32'(e_pop));
    chk("irq_ack", 32'(irq_ack), 32'(e_ack));
    if (e_push) chk("push_data", 32'(stack_push_data), 32'(e_pdata));
    @(posedge clk); #1;
    check_state();
  endtask

  initial begin
    do_reset();
    // Sequential increment and wrap
    repeat (3) step(1, 0, 0, 0, 0);
    chk("pc_after_3_next", 32'(pc), 32'h003);
    step(1, 1, 'h7FF, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pc_wrap", 32'(pc), 32'h000);
    // CALL / RET pair
    step(1, 1, 'h010, 0, 0);
    step(1, 2, 'h100, 0, 0);
    chk("call_pc", 32'(pc), 32'h100);
    step(1, 3, 0, 0, 0);
    chk("ret_pc", 32'(pc), 32'h011);
    // Overflow: 32 nested calls then one more
    for (int i = 0; i < DEPTH; i++) step(1, 2, i * 3, 0, 0);
    chk("depth_full", 32'(depth), 32'd32);
    step(1, 2, 'h055, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    chk("ovf_code", 32'(fault_code), 32'd1);
    // Underflow, then illegal RETI outside a handler
    do_reset();
    step(1, 3, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    chk("unf_code_sticky", 32'(fault_code), 32'd2);
    do_reset();
    step(1, 4, 0, 0, 0);
    chk("reti_code", 32'(fault_code), 32'd3);
    do_reset();
    step(1, 6, 0, 0, 0);
    // Interrupt entry pre-empting a NEXT, then return
    do_reset();
    step(1, 1, 'h020, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    chk("irq_pc", 32'(pc), 32'h7F0);
    step(1, 4, 0, 0, 1);
    chk("reti_pc", 32'(pc), 32'h020);
    // Request during handler stays pending until RETI
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    step(1, 4, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    // Request held while disabled
    step(1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    // Entry with full stack faults and withholds the ack
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 2, i + 7, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    chk("irq_ovf_code", 32'(fault_code), 32'd1);
    // Random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int r, op;
      r = $urandom_range(0, 99);
      op = (r < 35) ? 0 : (r < 50) ? 1 : (r < 70) ? 2 : (r < 86) ? 3 : (r < 95) ? 4
         : $urandom_range(5, 7);
      step($urandom_range(0, 9) < 8, op, $urandom_range(0, 2047),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
      if (m_fault && $urandom_range(0, 3) == 0) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 11'h000, PC value loaded on reset.
REQ-002 SHALL have parameter IRQ_VECTOR, default 11'h7F0, PC value loaded on interrupt entry.
REQ-003 SHALL have parameter DEPTH, default 32, call-stack capacity; must match the attached 32x11 PC stack.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cmd_valid  input  1  command present this cycle.
REQ-007 SHALL have port cmd_op  input  3  opcode: 0 NEXT, 1 JUMP, 2 CALL, 3 RET, 4 RETI, 5-7 illegal.
REQ-008 SHALL have port target  input  11  destination for JUMP/CALL.
REQ-009 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-010 SHALL have port irq_req  input  1  one-cycle interrupt request pulse.
REQ-011 SHALL have port irq_en  input  1  global interrupt enable.
REQ-012 SHALL have port irq_ack  output  1  one-cycle pulse in the cycle interrupt entry is taken.
REQ-013 SHALL have port pc  output  11  current program counter (registered).
REQ-014 SHALL have port stack_push / stack_push_data  output  1 / 11  push strobe and data to PC stack.
REQ-015 SHALL have port stack_pop  output  1  pop strobe to PC stack.
REQ-016 SHALL have port stack_pop_data  input  11  top-of-stack from PC stack (combinational there).
REQ-017 SHALL have port depth  output  6  mirrored stack occupancy, 0..DEPTH.
REQ-018 SHALL have port in_isr  output  1  interrupt handler active.
REQ-019 SHALL have port fault / fault_code  output  1 / 2  sticky fault; code 1 overflow, 2 underflow, 3 illegal.

Function
REQ-020 SHALL implement states RUN, IRQ_ENTRY-decision (combinational within RUN) and FAULT; FAULT exits only via rst.
REQ-021 SHALL drive cmd_ready=1 in RUN except in a cycle where interrupt entry is taken; cmd_ready=0 in FAULT.
REQ-022 SHALL drive stack_push, stack_pop combinationally in the same cycle the operation is accepted; never both high in one cycle; both 0 in FAULT.
REQ-023 NEXT: pc<=pc+1, modulo 2^11 (11'h7FF -> 11'h000); no stack activity.
REQ-024 JUMP: pc<=target; no stack activity.
REQ-025 CALL with depth<DEPTH: stack_push=1, stack_push_data=pc+1 (mod 2^11), pc<=target, depth<=depth+1.
REQ-026 CALL with depth==DEPTH: no push, pc unchanged, enter FAULT, fault_code=1.
REQ-027 RET with depth>0: stack_pop=1, pc<=stack_pop_data, depth<=depth-1.
REQ-028 RET with depth==0: no pop, pc unchanged, enter FAULT, fault_code=2.
REQ-029 RETI: as RET plus in_isr<=0; RETI with in_isr==0 SHALL fault with code 3 (takes priority over underflow).
REQ-030 Illegal opcode (5-7) with cmd_valid: enter FAULT, code 3, pc unchanged.
REQ-031 No cmd_valid and no interrupt entry: pc, depth hold.
REQ-032 irq_pending SHALL be set by irq_req, cleared on entry; set has priority when both coincide.
REQ-033 Entry taken in RUN when irq_pending && irq_en && !in_isr, regardless of cmd_valid; command that cycle is not accepted.
REQ-034 Entry with depth<DEPTH: stack_push=1, stack_push_data=pc (unexecuted), pc<=IRQ_VECTOR, depth+1, in_isr<=1, irq_ack=1.
REQ-035 Entry with depth==DEPTH: no push, enter FAULT code 1, irq_ack=0, pending retained.
REQ-036 fault/fault_code SHALL record only the first fault; later events ignored until rst.
REQ-037 irq_req while in_isr or irq_en=0 SHALL remain pending (no nesting, no loss).

Reset
REQ-038 rst SHALL set pc=RESET_VECTOR, depth=0, state RUN, irq_pending=0, in_isr=0, fault=0, fault_code=0; same rst drives the PC stack.
REQ-039 During rst cycle SHALL assert no strobe (stack_push, stack_pop, irq_ack =0); rst mid-operation discards the in-flight command and pending interrupt.

Verification
REQ-040 Reset, 3x NEXT -> pc=003; pc=7FF + NEXT -> pc=000.
REQ-041 pc=010, CALL 100 -> push data 011, pc=100, depth=1; RET -> pop, pc=011, depth=0.
REQ-042 32 nested CALLs -> depth=32; 33rd CALL -> no push, fault=1, code=1, cmd_ready=0 until rst.
REQ-043 RET at depth=0 -> fault code 2, pc unchanged; RETI with in_isr=0 -> code 3.
REQ-044 pc=020, irq_en=1, irq_req pulse with cmd_valid NEXT same next cycle -> irq_ack, push 020, pc=7F0, in_isr=1, NEXT not accepted; RETI -> pc=020, in_isr=0.
REQ-045 irq_req while in_isr=1 -> no entry; after RETI, entry taken next cycle with irq_ack=1.
